keypoint_collector: RTL and testbench

Downstream stage of the keypoint detector. Consumes the detector's per-pixel byte stream (Dout / keypoint_valid), tracks raster position, and thresholds each sample. Qualifying pixels are pushed as {y, x, score} records into an internal FIFO, which is drained over a valid/ready interface to the display or host.

---
 rtl/keypoint_collector.sv | 180 ++++++++++++++++++
 tb/tb_keypoint_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_collector.sv
// Keypoint collector: tracks the raster position of the detector stream, thresholds
// each sample, and queues {y, x, score} records for a valid/ready consumer.
module keypoint_collector #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned DEPTH  = 16,
  parameter logic [7:0]  THRESH = 8'd1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic           kp_valid,
  input  logic [7:0]     kp_data,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic [7:0]     out_score,
  output logic [15:0]    kp_count,
  output logic           overflow,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [X_W-1:0] COL_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(IMG_H - 1);

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
    logic [7:0]     score;
  } rec_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             busy_d, done_d;
  logic [X_W-1:0]   col_q;
  logic [Y_W-1:0]   row_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_nxt_c;
  logic [CNT_W-1:0] count_q, count_d;
  rec_t             mem [DEPTH];
  rec_t             head_q, head_d, new_rec_c;
  logic             out_valid_d;

  logic sample_c, last_pix_c, qual_c, pop_c, full_c, push_c, drop_c;

  assign sample_c   = kp_valid && (state_q == ACTIVE) && !frame_start;
  assign last_pix_c = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign qual_c     = sample_c && (kp_data >= THRESH);
  assign pop_c      = out_valid && out_ready && !frame_start;
  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign push_c     = qual_c && (!full_c || pop_c);
  assign drop_c     = qual_c && full_c && !pop_c;
  assign rd_nxt_c   = rd_ptr_q + PTR_W'(1);
  assign new_rec_c  = '{y: row_q, x: col_q, score: kp_data};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; DRAIN leaves on the cycle the FIFO goes empty
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ACTIVE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACTIVE:  if (sample_c && last_pix_c) state_d = DRAIN;
        DRAIN:   if (count_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs, computed from the next state so the registers line up with it
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == DRAIN) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Raster position and per-frame statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      kp_count <= '0;
      overflow <= 1'b0;
    end else if (frame_start) begin
      col_q    <= '0;
      row_q    <= '0;
      kp_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (sample_c) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + Y_W'(1);
        end else begin
          col_q <= col_q + X_W'(1);
        end
      end
      if (qual_c && (kp_count != 16'hFFFF)) kp_count <= kp_count + 16'd1;
      if (drop_c) overflow <= 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (frame_start)          count_d = '0;
    else if (push_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (frame_start) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_nxt_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= new_rec_c;
  end

  // Head register: a push into an empty (or emptying) FIFO bypasses storage
  always_comb begin
    head_d      = head_q;
    out_valid_d = 1'b0;
    if (!frame_start) begin
      out_valid_d = (count_d != '0);
      if (push_c && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_c)))
        head_d = new_rec_c;
      else if (pop_c && (count_q > CNT_W'(1)))
        head_d = mem[rd_nxt_c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      head_q    <= head_d;
      out_valid <= out_valid_d;
    end
  end

  assign out_x     = head_q.x;
  assign out_y     = head_q.y;
  assign out_score = head_q.score;

endmodule

// File: tb/tb_keypoint_collector.sv
// Scoreboard bench for keypoint_collector on a 4x3 image with a 4-entry FIFO.
module tb_keypoint_collector;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned DEPTH  = 4;
  localparam logic [7:0]  THRESH = 8'h10;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
    logic [7:0]     s;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_start = 1'b0;
  logic           kp_valid = 1'b0;
  logic [7:0]     kp_data = 8'h00;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [7:0]     out_score;
  logic [15:0]    kp_count;
  logic           overflow;
  logic           busy;
  logic           frame_done;

  keypoint_collector #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .THRESH(THRESH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .kp_valid(kp_valid),
    .kp_data(kp_data), .out_ready(out_ready), .out_valid(out_valid), .out_x(out_x),
    .out_y(out_y), .out_score(out_score), .kp_count(kp_count), .overflow(overflow),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   m_col = 0;
  int   m_row = 0;
  int   m_kp = 0;
  bit   m_active = 1'b0;
  bit   m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records are compared as they are popped; frame_done cycles are counted
  always @(negedge clk) begin
    if (rst_n && !frame_start) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_rec", 32'(exp_q.size()), 32'd1);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          check("rec_x", 32'(out_x), 32'(r.x));
          check("rec_y", 32'(out_y), 32'(r.y));
          check("rec_score", 32'(out_score), 32'(r.s));
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic drive_sample(input logic [7:0] d);
    rec_t r;
    kp_valid = 1'b1;
    kp_data  = d;
    if (m_active) begin
      if (d >= THRESH) begin
        if (m_kp < 65535) m_kp++;
        if ((exp_q.size() < int'(DEPTH)) || (out_valid && out_ready)) begin
          r.y = Y_W'(m_row);
          r.x = X_W'(m_col);
          r.s = d;
          exp_q.push_back(r);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_col == int'(IMG_W) - 1) begin
        m_col = 0;
        if (m_row == int'(IMG_H) - 1) begin
          m_row = 0;
          m_active = 1'b0;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    tick();
    kp_valid = 1'b0;
  endtask

  // Optional sample in the same cycle as frame_start must be discarded
  task automatic do_frame_start(input bit with_sample, input logic [7:0] d);
    frame_start = 1'b1;
    kp_valid = with_sample;
    kp_data = d;
    exp_q.delete();
    m_active = 1'b1;
    m_col = 0;
    m_row = 0;
    m_kp = 0;
    m_ovf = 1'b0;
    tick();
    frame_start = 1'b0;
    kp_valid = 1'b0;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive_sample(8'h00);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt == exp_done + 1) break;
      tick();
    end
    exp_done++;
    repeat (3) tick();
    check("frame_done_once", 32'(done_cnt), 32'(exp_done));
    check("busy_idle", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("kp_count", 32'(kp_count), 32'(m_kp));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_x"}, 32'(out_x), 32'd0);
    check({tag, "_out_y"}, 32'(out_y), 32'd0);
    check({tag, "_out_score"}, 32'(out_score), 32'd0);
    check({tag, "_kp_count"}, 32'(kp_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single keypoint at pixel 5, consumer always ready
    out_ready = 1'b1;
    do_frame_start(1'b0, 8'h00);
    check("busy_active", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      drive_sample((i == 5) ? 8'h20 : 8'h00);
      if (i == 5) check("latency1_valid", 32'(out_valid), 32'd1);
    end
    check("busy_drain", 32'(busy), 32'd1);
    wait_done(20);

    // Overflow: six keypoints, consumer stalled
    out_ready = 1'b0;
    do_frame_start(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) drive_sample(8'h30 + 8'(i));
    zeros(6);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_kp_count", 32'(kp_count), 32'd6);
    repeat (3) tick();
    check("drain_busy_held", 32'(busy), 32'd1);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_score", 32'(out_score), 32'h30);
    check("stall_x", 32'(out_x), 32'd0);
    check("no_done_while_full", 32'(done_cnt), 32'(exp_done));
    out_ready = 1'b1;
    wait_done(20);

    // Full FIFO with a pop in the push cycle accepts the push
    out_ready = 1'b0;
    do_frame_start(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive_sample(8'h40 + 8'(i));
    out_ready = 1'b1;
    drive_sample(8'h44);
    check("full_pop_no_ovf", 32'(overflow), 32'd0);
    zeros(7);
    wait_done(20);

    // Mid-frame restart with two queued records and a same-cycle sample
    out_ready = 1'b0;
    do_frame_start(1'b0, 8'h00);
    drive_sample(8'h50);
    drive_sample(8'h51);
    zeros(5);
    check("queued_valid", 32'(out_valid), 32'd1);
    check("queued_kp_count", 32'(kp_count), 32'd2);
    do_frame_start(1'b1, 8'h55);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_kp_count", 32'(kp_count), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    drive_sample(8'h56);
    zeros(11);
    wait_done(20);

    // Samples in IDLE are ignored
    for (int i = 0; i < 3; i++) drive_sample(8'h60);
    check("idle_kp_count", 32'(kp_count), 32'(m_kp));
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Threshold boundary, then samples in DRAIN are ignored
    out_ready = 1'b0;
    do_frame_start(1'b0, 8'h00);
    drive_sample(8'h10);
    drive_sample(8'h0F);
    zeros(10);
    for (int i = 0; i < 3; i++) drive_sample(8'h70);
    check("thresh_kp_count", 32'(kp_count), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_head_score", 32'(out_score), 32'h10);
    out_ready = 1'b1;
    wait_done(20);

    // Asynchronous reset in the middle of a drain
    out_ready = 1'b0;
    do_frame_start(1'b0, 8'h00);
    drive_sample(8'h77);
    zeros(10);
    drive_sample(8'h78);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    #1;
    check_all_zero("async_reset");
    #10;
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_valid", 32'(out_valid), 32'd0);
    check("post_reset_done", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
